// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared write-back widths, constants and one-hot register decode.
package wb_arbiter_pkg;
    typedef logic [4:0]  reg_addr_bus_t;
    typedef logic [31:0] reg_bus_t;
    localparam reg_bus_t ZeroWord  = 32'h0;
    localparam logic     RstEnable = 1'b0;
    localparam logic     WbSrcAlu  = 1'b0;
    localparam logic     WbSrcMem  = 1'b1;
    typedef struct packed {
        reg_addr_bus_t addr;
        reg_bus_t      data;
    } wb_entry_t;
    function automatic logic [31:0] reg_onehot(input reg_addr_bus_t a);
        reg_onehot = (a == 5'd0) ? 32'h0 : (32'h1 << a);
    endfunction
endpackage

// File: rtl/wb_queue.sv
// wb_queue: 2-entry write-back FIFO exposing its head and a one-hot mask of queued destinations.
module wb_queue
    import wb_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  wb_entry_t   din,
    output logic [1:0]  count,
    output wb_entry_t   head,
    output logic [31:0] mask
);
    wb_entry_t mem [2];
    logic      hd, tl;
    always_ff @(posedge clk or negedge rst)
        if (rst == RstEnable) begin
            hd    <= 1'b0;
            tl    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) tl <= ~tl;
            if (pop) hd <= ~hd;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    always_ff @(posedge clk)
        if (push) mem[tl] <= din;
    assign head = mem[hd];
    assign mask = (count == 2'd2) ? (reg_onehot(mem[0].addr) | reg_onehot(mem[1].addr)) :
                  (count == 2'd1) ? reg_onehot(mem[hd].addr) : 32'h0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between ALU and load results,
// with source 1 priority, a starvation override for source 0, and a pending-write mask.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  reg_addr_bus_t s0_addr,
    input  reg_bus_t      s0_data,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  reg_addr_bus_t s1_addr,
    input  reg_bus_t      s1_data,
    output logic          we,
    output reg_addr_bus_t wr_addr,
    output reg_bus_t      wr_data,
    output logic [31:0]   pending,
    output logic          conflict
);
    logic [1:0]  c0, c1, starve_cnt;
    logic [31:0] m0, m1;
    wb_entry_t   h0, h1, win;
    logic        push0, push1, v0, v1, g0, g1, grant_src;

    assign s0_ready = (rst != RstEnable) && (c0 != 2'd2);
    assign s1_ready = (rst != RstEnable) && (c1 != 2'd2);
    assign push0    = s0_valid && s0_ready;
    assign push1    = s1_valid && s1_ready;
    assign v0       = c0 != 2'd0;
    assign v1       = c1 != 2'd0;
    // Source 1 wins ties until source 0 has lost STARVE_LIMIT cycles in a row.
    assign grant_src = (v1 && !(v0 && int'(starve_cnt) >= STARVE_LIMIT)) ? WbSrcMem : WbSrcAlu;
    assign g1       = v1 && grant_src == WbSrcMem;
    assign g0       = v0 && grant_src == WbSrcAlu;
    assign win      = (grant_src == WbSrcMem) ? h1 : h0;
    assign pending  = m0 | m1 | (we ? reg_onehot(wr_addr) : 32'h0);

    wb_queue u_q0 (
        .clk(clk), .rst(rst), .push(push0), .pop(g0),
        .din('{addr: s0_addr, data: s0_data}), .count(c0), .head(h0), .mask(m0)
    );
    wb_queue u_q1 (
        .clk(clk), .rst(rst), .push(push1), .pop(g1),
        .din('{addr: s1_addr, data: s1_data}), .count(c1), .head(h1), .mask(m1)
    );

    always_ff @(posedge clk or negedge rst)
        if (rst == RstEnable) begin
            we         <= 1'b0;
            wr_addr    <= 5'd0;
            wr_data    <= ZeroWord;
            starve_cnt <= 2'd0;
            conflict   <= 1'b0;
        end else begin
            starve_cnt <= (v0 && !g0) ? ((starve_cnt == 2'd3) ? starve_cnt : starve_cnt + 2'd1) : 2'd0;
            conflict   <= conflict | (push0 && |(pending & reg_onehot(s0_addr)))
                                   | (push1 && |(pending & reg_onehot(s1_addr)));
            we         <= (g0 || g1) && win.addr != 5'd0;
            // x0 results are consumed here but never written.
            if (g0 || g1) begin
                wr_addr <= win.addr;
                wr_data <= (win.addr == 5'd0) ? ZeroWord : win.data;
            end
        end
endmodule
